// File: rtl/uart_tx_64.sv
// uart_tx_64: accepts one 64-bit word over a valid/ready handshake and
// serializes it as eight back-to-back 8N1 UART frames, MSB byte first,
// each byte LSB first.
//
// Ports:
//   clk        system clock, rising edge
//   rst_n      asynchronous active-low reset
//   data_64    word to transmit, sampled on accept (data_valid && data_ready)
//   data_valid word present on data_64
//   data_ready high only while idle; the block can take a word
//   uart_txd   serial line, idle high, driven straight from a flop
//   tx_busy    high from the cycle after accept until the last stop bit ends
//   tx_done    one-cycle pulse when the 8th stop bit completes
module uart_tx_64 #(
  parameter int unsigned CLK_FREQ = 50_000_000,
  parameter int unsigned UART_BPS = 115200
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [63:0] data_64,
  input  logic        data_valid,
  output logic        data_ready,
  output logic        uart_txd,
  output logic        tx_busy,
  output logic        tx_done
);

  localparam int unsigned BPS_CNT = CLK_FREQ / UART_BPS;
  localparam int unsigned CNT_W   = (BPS_CNT > 1) ? $clog2(BPS_CNT) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP
  } state_e;

  state_e             state_q, state_d;
  logic [63:0]        shift_q, shift_d;
  logic [2:0]         bit_idx_q, bit_idx_d;
  logic [2:0]         byte_idx_q, byte_idx_d;
  logic [CNT_W-1:0]   baud_q, baud_d;
  logic               txd_q, txd_d;
  logic               ready_q, ready_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  logic               baud_end;
  logic [7:0]         cur_byte;

  assign baud_end = (baud_q == CNT_W'(BPS_CNT - 1));
  // The byte in flight always sits in the top lane; the register shifts by a
  // byte at each frame boundary.
  assign cur_byte = shift_q[63:56];

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      shift_q    <= '0;
      bit_idx_q  <= '0;
      byte_idx_q <= '0;
      baud_q     <= '0;
      txd_q      <= 1'b1;
      ready_q    <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      bit_idx_q  <= bit_idx_d;
      byte_idx_q <= byte_idx_d;
      baud_q     <= baud_d;
      txd_q      <= txd_d;
      ready_q    <= ready_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  // Next-state logic; txd_d is the line level for the state being entered
  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    bit_idx_d  = bit_idx_q;
    byte_idx_d = byte_idx_q;
    baud_d     = baud_q + CNT_W'(1);
    txd_d      = txd_q;
    done_d     = 1'b0;

    case (state_q)
      S_IDLE: begin
        baud_d = '0;
        txd_d  = 1'b1;
        if (data_valid && ready_q) begin
          state_d    = S_START;
          shift_d    = data_64;
          byte_idx_d = '0;
          bit_idx_d  = '0;
          txd_d      = 1'b0;
        end
      end
      S_START: begin
        if (baud_end) begin
          baud_d    = '0;
          state_d   = S_DATA;
          bit_idx_d = '0;
          txd_d     = cur_byte[0];
        end
      end
      S_DATA: begin
        if (baud_end) begin
          baud_d = '0;
          if (bit_idx_q == 3'd7) begin
            state_d = S_STOP;
            txd_d   = 1'b1;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
            txd_d     = cur_byte[bit_idx_q + 3'd1];
          end
        end
      end
      S_STOP: begin
        if (baud_end) begin
          baud_d = '0;
          if (byte_idx_q == 3'd7) begin
            state_d = S_IDLE;
            txd_d   = 1'b1;
            done_d  = 1'b1;
          end else begin
            state_d    = S_START;
            byte_idx_d = byte_idx_q + 3'd1;
            shift_d    = {shift_q[55:0], 8'h00};
            txd_d      = 1'b0;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
        baud_d  = '0;
        txd_d   = 1'b1;
      end
    endcase

    ready_d = (state_d == S_IDLE);
    busy_d  = (state_d != S_IDLE);
  end

  assign uart_txd   = txd_q;
  assign data_ready = ready_q;
  assign tx_busy    = busy_q;
  assign tx_done    = done_q;

endmodule

// File: tb/tb_uart_tx_64.sv
// Self-checking bench for uart_tx_64 with BPS_CNT = 10.
module tb_uart_tx_64;

  localparam int unsigned CLK_FREQ = 1_000_000;
  localparam int unsigned UART_BPS = 100_000;
  localparam int          B        = 10;
  localparam int          WORD_CYC = 80 * B;

  logic        clk;
  logic        rst_n;
  logic [63:0] data_64;
  logic        data_valid;
  logic        data_ready;
  logic        uart_txd;
  logic        tx_busy;
  logic        tx_done;

  int total;
  int bad;

  uart_tx_64 #(
    .CLK_FREQ(CLK_FREQ),
    .UART_BPS(UART_BPS)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .data_64   (data_64),
    .data_valid(data_valid),
    .data_ready(data_ready),
    .uart_txd  (uart_txd),
    .tx_busy   (tx_busy),
    .tx_done   (tx_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] data;
    logic [7:0]  bytes [8];
    int          poke;   // cycle to pulse an all-ones word while busy, -1 = none
  } vec_t;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference line level n cycles into a word: 80 bit periods of B clocks,
  // each frame = start(0), 8 data bits LSB first, stop(1); bytes MSB first.
  function automatic logic ref_line(input logic [63:0] w, input int n);
    int p, f, k;
    logic [7:0] b;
    p = n / B;
    f = p / 10;
    k = p % 10;
    if (k == 0) return 1'b0;
    if (k == 9) return 1'b1;
    b = 8'(w >> (56 - 8 * f));
    return b[k - 1];
  endfunction

  // Drive a word from idle; returns at the first negedge after the accept edge.
  task automatic start_word(input logic [63:0] w);
    data_64    = w;
    data_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    data_valid = 1'b0;
    data_64    = {$urandom, $urandom};
  endtask

  // Check a whole word starting at its first serial cycle. Optionally poke an
  // ignored word mid-flight, or hold valid high with next_w so it is accepted
  // in the tx_done cycle. Returns the word decoded from mid-bit samples.
  task automatic check_word(input string tag, input logic [63:0] w, input int poke,
                            input bit chain, input logic [63:0] next_w,
                            output logic [63:0] decoded);
    int wave_err, ctl_err, frame_err;
    logic [9:0] fr;
    wave_err = 0; ctl_err = 0; frame_err = 0; decoded = '0; fr = '0;
    if (chain) begin
      data_valid = 1'b1;
      data_64    = next_w;
    end
    for (int n = 0; n < WORD_CYC; n++) begin
      if (uart_txd !== ref_line(w, n)) wave_err++;
      if (tx_busy !== 1'b1 || data_ready !== 1'b0 || tx_done !== 1'b0) ctl_err++;
      if (n % B == B / 2) begin
        fr[(n / B) % 10] = uart_txd;
        if ((n / B) % 10 == 9) begin
          if (fr[0] !== 1'b0 || fr[9] !== 1'b1) frame_err++;
          decoded = {decoded[55:0], fr[8:1]};
        end
      end
      if (!chain && n == poke) begin
        data_valid = 1'b1;
        data_64    = 64'hFFFF_FFFF_FFFF_FFFF;
      end else if (!chain && n == poke + 1) begin
        data_valid = 1'b0;
      end
      @(negedge clk);
    end
    chk({tag, " wave"}, 64'(wave_err), 64'd0);
    chk({tag, " busy/ready"}, 64'(ctl_err), 64'd0);
    chk({tag, " framing"}, 64'(frame_err), 64'd0);
    chk({tag, " done pulse"}, {61'd0, tx_done, tx_busy, data_ready}, 64'b101);
    chk({tag, " line idle"}, 64'(uart_txd), 64'd1);
    @(negedge clk);
    data_valid = 1'b0;
    chk({tag, " done one cycle"}, 64'(tx_done), 64'd0);
  endtask

  vec_t        vecs [3];
  logic [63:0] dec;
  logic [63:0] exp_w;
  logic [63:0] rw;

  initial begin
    total      = 0;
    bad        = 0;
    rst_n      = 1'b0;
    data_64    = '0;
    data_valid = 1'b0;

    vecs[0].data = 64'h0123_4567_89AB_CDEF;
    vecs[0].bytes = '{8'h01, 8'h23, 8'h45, 8'h67, 8'h89, 8'hAB, 8'hCD, 8'hEF};
    vecs[0].poke = -1;
    vecs[1].data = 64'h1122_3344_5566_7788;
    vecs[1].bytes = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
    vecs[1].poke = 137;
    vecs[2].data = 64'hDEAD_BEEF_CAFE_F00D;
    vecs[2].bytes = '{8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'hCA, 8'hFE, 8'hF0, 8'h0D};
    vecs[2].poke = WORD_CYC - 2;

    repeat (3) @(negedge clk);
    chk("reset txd", 64'(uart_txd), 64'd1);
    chk("reset ready/busy/done", {61'd0, data_ready, tx_busy, tx_done}, 64'b100);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("idle ready", 64'(data_ready), 64'd1);

    // Table-driven words, including ignored pulses while busy
    foreach (vecs[i]) begin
      start_word(vecs[i].data);
      check_word($sformatf("vec%0d", i), vecs[i].data, vecs[i].poke, 1'b0, '0, dec);
      exp_w = '0;
      for (int j = 0; j < 8; j++) exp_w = {exp_w[55:0], vecs[i].bytes[j]};
      chk($sformatf("vec%0d bytes", i), dec, exp_w);
      repeat (3) @(negedge clk);
    end

    // Back-to-back: valid held high, second word taken in the tx_done cycle
    start_word(64'h0000_0000_0000_0000);
    check_word("b2b0", 64'h0, -1, 1'b1, 64'hA5A5_5A5A_FFFF_0001, dec);
    chk("b2b0 bytes", dec, 64'h0);
    check_word("b2b1", 64'hA5A5_5A5A_FFFF_0001, -1, 1'b0, '0, dec);
    chk("b2b1 bytes", dec, 64'hA5A5_5A5A_FFFF_0001);

    // Randomized words against the reference line model
    for (int r = 0; r < 5; r++) begin
      rw = {$urandom, $urandom};
      repeat ($urandom_range(0, 4)) @(negedge clk);
      start_word(rw);
      check_word($sformatf("rnd%0d", r), rw, int'($urandom_range(0, WORD_CYC - 2)), 1'b0, '0, dec);
      chk($sformatf("rnd%0d bytes", r), dec, rw);
    end

    // Asynchronous reset mid-frame, observed before any clock edge
    start_word(64'hFFFF_0000_FFFF_0000);
    repeat (235) @(negedge clk);
    chk("pre-reset busy", 64'(tx_busy), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("async reset txd", 64'(uart_txd), 64'd1);
    chk("async reset ready/busy/done", {61'd0, data_ready, tx_busy, tx_done}, 64'b100);
    @(negedge clk);
    rst_n = 1'b1;
    begin
      int stray;
      stray = 0;
      for (int n = 0; n < 3 * B; n++) begin
        @(negedge clk);
        if (uart_txd !== 1'b1 || tx_done !== 1'b0 || tx_busy !== 1'b0) stray++;
      end
      chk("post-reset quiet", 64'(stray), 64'd0);
    end

    // Recovery after reset
    start_word(64'h0F1E_2D3C_4B5A_6978);
    check_word("post-reset word", 64'h0F1E_2D3C_4B5A_6978, -1, 1'b0, '0, dec);
    chk("post-reset bytes", dec, 64'h0F1E_2D3C_4B5A_6978);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
